// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads two ROM bytes at pc/pc+1 and offers the
// big-endian 16-bit word on a valid/ready handshake. Optional IFETCH_ALIGN_CHECK_EN.
module instr_fetch #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic                  pc_advance_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_rd_en_o,
  input  logic [7:0]            rom_data_i,
  output logic [15:0]           instr_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o,
  output logic                  misalign_err_o
);

  typedef enum logic [2:0] {
    S_HI,
    S_LO,
    S_CAP,
`ifdef IFETCH_ALIGN_CHECK_EN
    S_ERR,
`endif
    S_VALID
  } state_t;

  state_t      state_q;
  logic [7:0]  hiByte_q;
  logic [15:0] instr_q;
  logic        instrValid_q;
  logic        inErr;
  logic        accept;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;
  assign inErr          = (state_q == S_ERR);
  assign misalign_err_o = misalign_q;
`else
  assign inErr          = 1'b0;
  assign misalign_err_o = 1'b0;
`endif

  // An accept is suppressed whenever a flush is redirecting the PC.
  assign accept        = (state_q == S_VALID) && instrValid_q && instr_ready_i && !flush_i;
  assign pc_advance_o  = accept;
  assign busy_o        = (state_q != S_VALID);
  assign instr_o       = instr_q;
  assign instr_valid_o = instrValid_q;

  always_comb begin
    rom_addr_o  = '0;
    rom_rd_en_o = 1'b0;
    case (state_q)
      S_HI: begin
        rom_addr_o = pc_i;
`ifdef IFETCH_ALIGN_CHECK_EN
        rom_rd_en_o = !pc_i[0];
`else
        rom_rd_en_o = 1'b1;
`endif
      end
      S_LO: begin
        rom_addr_o  = ADDR_WIDTH'(pc_i + 1'b1);
        rom_rd_en_o = 1'b1;
      end
      default: begin
        rom_addr_o  = '0;
        rom_rd_en_o = 1'b0;
      end
    endcase
  end

  // The error state is terminal: only reset leaves it, flush included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HI;
      hiByte_q     <= 8'h00;
      instr_q      <= 16'h0000;
      instrValid_q <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else if (flush_i && !inErr) begin
      state_q      <= S_HI;
      instrValid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HI: begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (pc_i[0]) begin
            state_q    <= S_ERR;
            misalign_q <= 1'b1;
          end else begin
            state_q <= S_LO;
          end
`else
          state_q <= S_LO;
`endif
        end
        S_LO: begin
          hiByte_q <= rom_data_i;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          instr_q      <= {hiByte_q, rom_data_i};
          instrValid_q <= 1'b1;
          state_q      <= S_VALID;
        end
        S_VALID: begin
          if (instr_ready_i) begin
            instrValid_q <= 1'b0;
            state_q      <= S_HI;
          end
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        S_ERR: begin
          state_q <= S_ERR;
        end
`endif
        default: begin
          state_q <= S_HI;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the reader on the program-counter/ROM path. It takes the current PC byte address and issues two byte reads to the byte-wide instruction ROM. It assembles the two bytes into a 16-bit instruction and presents it downstream on a valid/ready handshake. When the instruction is accepted, it pulses the PC's advance enable so the PC steps by 2 to the next instruction.

## Interface
- ADDR_WIDTH, 3, byte-address width of the ROM and the PC.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pc  in  ADDR_WIDTH  current PC byte address; must hold stable except on pc_advance or a flush edge.
- flush  in  1  synchronous; a branch or jump is loading the PC this cycle, so discard the fetch in flight.
- pc_advance  out  1  one-cycle enable to the PC (PC increments by 2 on that edge).
- rom_addr  out  ADDR_WIDTH  ROM byte address.
- rom_rd_en  out  1  ROM read strobe.
- rom_data  in  8  ROM read data, valid exactly 1 cycle after rom_rd_en.
- instr  out  16  assembled instruction: {byte@pc, byte@pc+1}, big-endian.
- instr_valid  out  1  instr holds a complete instruction.
- instr_ready  in  1  downstream accepts instr.
- busy  out  1  high in any state other than S_VALID.
- misalign_err  out  1  sticky alignment error; tied 0 unless IFETCH_ALIGN_CHECK_EN is defined.

## Operation
FSM with registered state. States and their outputs:
- S_HI: rom_addr=pc, rom_rd_en=1. Next state S_LO.
- S_LO: capture rom_data into hi_byte. rom_addr=(pc+1) mod 2^ADDR_WIDTH, rom_rd_en=1. Next state S_CAP.
- S_CAP: register instr={hi_byte, rom_data} and set instr_valid. Next state S_VALID.
- S_VALID: instr_valid=1 and instr held. On instr_valid&instr_ready: pc_advance=1 (combinational in that cycle), clear instr_valid, next state S_HI. Otherwise stay in S_VALID.
- S_ERR: only exists when IFETCH_ALIGN_CHECK_EN is defined; see Configuration.

Outputs and arithmetic:
- rom_rd_en=0 and rom_addr=0 in every state not listed above as driving them.
- pc+1 wraps modulo 2^ADDR_WIDTH; there is no carry out.

Flush:
- flush has priority over every other event.
- Next state is S_HI, and instr_valid clears on the next edge.
- pc_advance is forced 0 in the flush cycle, even if instr_ready=1.
- The next S_HI reads the newly loaded pc.

Reset:
- The state goes to S_HI.
- instr=16'h0000, instr_valid=0, pc_advance=0, rom_rd_en=1 (S_HI is active during reset), rom_addr=pc, misalign_err=0, busy=1.
- Reset mid-fetch abandons the partial instruction; hi_byte is cleared.

## Timing
- Fetch latency: 3 cycles from entering S_HI to instr_valid=1, which is the cycle the FSM enters S_VALID.
- Peak throughput: 1 instruction per 4 cycles, with instr_ready held 1.
- pc_advance is high for exactly one cycle per accepted instruction. It is never asserted when instr_valid=0.
- instr and instr_valid change only on a clock edge or on reset.
- instr is stable while instr_valid=1 and instr_ready=0.
- ROM model: synchronous read; rom_data for the address presented in cycle N appears in cycle N+1.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - In S_HI, if pc[0]=1, enter S_ERR instead of S_LO. No read is issued that cycle.
  - S_ERR: misalign_err=1 (sticky), instr_valid=0, rom_rd_en=0, pc_advance=0.
  - S_ERR exits only on reset. flush is ignored in S_ERR.
- IFETCH_ALIGN_CHECK_EN undefined:
  - pc[0] is ignored; bytes are fetched from pc and pc+1 as given.
  - misalign_err is constant 0 and S_ERR is not built.

## Test plan
ROM bytes 0..7 = 12 34 56 78 9A BC DE F0; ADDR_WIDTH=3; the PC model steps by 2 on pc_advance.
- Reset, then instr_ready=1 for 16 cycles -> instr sequence 0x1234, 0x5678, 0x9ABC, 0xDEF0, one every 4 cycles. First instr_valid in cycle 3 after reset release. pc wraps 6->0.
- instr_ready=0 for 10 cycles after the first valid -> instr holds 0x1234, instr_valid stays 1, pc_advance=0, rom_rd_en=0. Raising ready gives one pc_advance pulse.
- flush in S_LO with the PC loaded to 4 -> no pc_advance, no valid for the old fetch, next instr=0x9ABC.
- flush and instr_ready together in S_VALID -> pc_advance=0, instr_valid drops, refetch from the new pc.
- reset asserted in S_CAP -> instr=0, instr_valid=0 immediately; a clean fetch restarts at pc=0.
- pc=7: with the macro off -> instr=0xF012. With IFETCH_ALIGN_CHECK_EN on -> misalign_err=1, no further reads until reset.
